// File: rtl/l2_line_responder.sv
// L2-side responder for the L1 line-fill protocol: a direct-mapped line store that refills
// missing lines from memory in MEM_BEAT_BITS beats and exports hit/miss/error status.
module l2_line_responder #(
    parameter int unsigned NUM_LINES     = 16,
    parameter int unsigned LINE_BITS     = 256,
    parameter int unsigned MEM_BEAT_BITS = 64,
    parameter int unsigned HIT_LATENCY   = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [31:0]              l2_addr_i,
    input  logic                     l2_request_i,
    output logic [LINE_BITS-1:0]     l2_data_o,
    output logic                     l2_done_o,
    output logic                     mem_req_valid_o,
    input  logic                     mem_req_ready_i,
    output logic [31:0]              mem_req_addr_o,
    input  logic                     mem_rsp_valid_i,
    input  logic [MEM_BEAT_BITS-1:0] mem_rsp_data_i,
    input  logic                     mem_rsp_last_i,
    output logic [15:0]              hit_count_o,
    output logic [15:0]              miss_count_o,
    output logic                     protocol_err_o
);

    localparam int unsigned IDX_W  = $clog2(NUM_LINES);
    localparam int unsigned TAG_W  = 27 - IDX_W;
    localparam int unsigned BEATS  = LINE_BITS / MEM_BEAT_BITS;
    localparam int unsigned BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int unsigned LAT_W  = $clog2(HIT_LATENCY + 1);

    typedef enum logic [2:0] {
        StIdle,
        StLookup,
        StMemReq,
        StMemFill,
        StRespond
    } state_e;

    state_e state_q, state_d;

    logic [26:0]          addr_q, addr_d;       // line address, byte offset dropped
    logic [LAT_W-1:0]     lat_cnt_q, lat_cnt_d;
    logic [BEAT_W-1:0]    beat_cnt_q, beat_cnt_d;
    logic [LINE_BITS-1:0] fill_q, fill_d;
    logic [LINE_BITS-1:0] data_q, data_d;
    logic [31:0]          req_addr_q, req_addr_d;
    logic [15:0]          hit_cnt_q, hit_cnt_d;
    logic [15:0]          miss_cnt_q, miss_cnt_d;
    logic                 err_q, err_d;

    logic [NUM_LINES-1:0] valid_q;
    logic [TAG_W-1:0]     tag_mem_q  [NUM_LINES];
    logic [LINE_BITS-1:0] line_mem_q [NUM_LINES];

    logic [IDX_W-1:0]     idx;
    logic [TAG_W-1:0]     tag;
    logic                 lookup_hit;
    logic                 lat_last;
    logic                 beat_last;
    logic                 fill_done;
    logic [LINE_BITS-1:0] fill_line;
    logic                 unused_addr;

    assign unused_addr = ^l2_addr_i[4:0];

    assign idx        = addr_q[IDX_W-1:0];
    assign tag        = addr_q[26:IDX_W];
    assign lookup_hit = valid_q[idx] && (tag_mem_q[idx] == tag);
    assign lat_last   = (lat_cnt_q == '0);
    assign beat_last  = (beat_cnt_q == BEAT_W'(BEATS - 1));
    assign fill_done  = (state_q == StMemFill) && mem_rsp_valid_i && beat_last;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:    if (l2_request_i) state_d = StLookup;
            StLookup:  if (lat_last) state_d = lookup_hit ? StRespond : StMemReq;
            StMemReq:  if (mem_req_ready_i) state_d = StMemFill;
            StMemFill: if (fill_done) state_d = StRespond;
            StRespond: state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    // FSM outputs
    always_comb begin
        l2_done_o       = (state_q == StRespond);
        mem_req_valid_o = (state_q == StMemReq);
    end

    // Current fill buffer with the incoming beat merged into its slot
    always_comb begin
        fill_line = fill_q;
        fill_line[beat_cnt_q * MEM_BEAT_BITS +: MEM_BEAT_BITS] = mem_rsp_data_i;
    end

    always_comb begin
        addr_d     = addr_q;
        lat_cnt_d  = lat_cnt_q;
        beat_cnt_d = beat_cnt_q;
        fill_d     = fill_q;
        data_d     = data_q;
        req_addr_d = req_addr_q;
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        err_d      = err_q;

        unique case (state_q)
            StIdle: begin
                if (l2_request_i) begin
                    addr_d    = l2_addr_i[31:5];
                    lat_cnt_d = LAT_W'(HIT_LATENCY - 1);
                end
            end
            StLookup: begin
                if (!lat_last) begin
                    lat_cnt_d = lat_cnt_q - LAT_W'(1);
                end else if (lookup_hit) begin
                    data_d = line_mem_q[idx];
                    if (hit_cnt_q != 16'hFFFF) hit_cnt_d = hit_cnt_q + 16'd1;
                end else begin
                    req_addr_d = {addr_q, 5'b0};
                    if (miss_cnt_q != 16'hFFFF) miss_cnt_d = miss_cnt_q + 16'd1;
                end
            end
            StMemReq: begin
                if (mem_req_ready_i) beat_cnt_d = '0;
            end
            StMemFill: begin
                if (mem_rsp_valid_i) begin
                    fill_d     = fill_line;
                    beat_cnt_d = beat_cnt_q + BEAT_W'(1);
                    if (beat_last) data_d = fill_line;
                end
            end
            default: ;
        endcase

        // Completion is by beat count; a misplaced last or a beat outside a fill only flags
        if (mem_rsp_valid_i) begin
            if (state_q != StMemFill) begin
                err_d = 1'b1;
            end else if (mem_rsp_last_i != beat_last) begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q     <= '0;
            lat_cnt_q  <= '0;
            beat_cnt_q <= '0;
            fill_q     <= '0;
            data_q     <= '0;
            req_addr_q <= '0;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
            err_q      <= 1'b0;
            valid_q    <= '0;
        end else begin
            addr_q     <= addr_d;
            lat_cnt_q  <= lat_cnt_d;
            beat_cnt_q <= beat_cnt_d;
            fill_q     <= fill_d;
            data_q     <= data_d;
            req_addr_q <= req_addr_d;
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
            err_q      <= err_d;
            if (fill_done) valid_q[idx] <= 1'b1;
        end
    end

    // Tag/data payload needs no reset; the valid bits gate every use
    always_ff @(posedge clk) begin
        if (fill_done) begin
            tag_mem_q[idx]  <= tag;
            line_mem_q[idx] <= fill_line;
        end
    end

    assign l2_data_o      = data_q;
    assign mem_req_addr_o = req_addr_q;
    assign hit_count_o    = hit_cnt_q;
    assign miss_count_o   = miss_cnt_q;
    assign protocol_err_o = err_q;

endmodule

// File: tb/tb_l2_line_responder.sv
// Bench for l2_line_responder: random and directed reads scored against a behavioural cache
// model, with a reactive memory model serving line refills.
module tb_l2_line_responder;

    localparam int NL    = 16;
    localparam int BEATS = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic [31:0]  l2_addr_i;
    logic         l2_request_i;
    logic [255:0] l2_data_o;
    logic         l2_done_o;
    logic         mem_req_valid_o;
    logic         mem_req_ready_i;
    logic [31:0]  mem_req_addr_o;
    logic         mem_rsp_valid_i;
    logic [63:0]  mem_rsp_data_i;
    logic         mem_rsp_last_i;
    logic [15:0]  hit_count_o;
    logic [15:0]  miss_count_o;
    logic         protocol_err_o;

    l2_line_responder dut (
        .clk             (clk),
        .reset           (reset),
        .l2_addr_i       (l2_addr_i),
        .l2_request_i    (l2_request_i),
        .l2_data_o       (l2_data_o),
        .l2_done_o       (l2_done_o),
        .mem_req_valid_o (mem_req_valid_o),
        .mem_req_ready_i (mem_req_ready_i),
        .mem_req_addr_o  (mem_req_addr_o),
        .mem_rsp_valid_i (mem_rsp_valid_i),
        .mem_rsp_data_i  (mem_rsp_data_i),
        .mem_rsp_last_i  (mem_rsp_last_i),
        .hit_count_o     (hit_count_o),
        .miss_count_o    (miss_count_o),
        .protocol_err_o  (protocol_err_o)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    // Reference model: which line address each index holds and the data it returned
    bit           mv [NL];
    logic [22:0]  mt [NL];
    logic [255:0] md [NL];
    logic [255:0] exp_q[$];
    logic [255:0] mem_q[$];
    logic [31:0]  maddr_q[$];
    int unsigned  exp_hits = 0;
    int unsigned  exp_miss = 0;
    int           issued = 0;
    int           dones  = 0;

    // Memory model knobs (written by the main process only)
    int stall_fix   = -1;
    int stall_max   = 3;
    int gap_max     = 2;
    bit early_last  = 1'b0;
    bit abort_mode  = 1'b0;
    int stray_req   = 0;
    // Memory model status (written by the memory process only)
    int abort_cnt   = 0;
    int stray_done  = 0;
    int mem_txn     = 0;

    task automatic check(input string name, input logic [255:0] got, input logic [255:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    function automatic logic [255:0] rand_line();
        logic [255:0] l;
        for (int i = 0; i < 8; i++) l[i*32 +: 32] = $urandom;
        return l;
    endfunction

    // Scoreboard monitor
    always @(negedge clk) begin
        logic [255:0] e;
        if (!reset && l2_done_o) begin
            dones++;
            if (exp_q.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("l2_data", l2_data_o, e);
            end
        end
    end

    // Memory answers one cycle after accepting a request; beats may have random gaps
    task automatic serve();
        int           stall;
        logic [31:0]  ea;
        logic [255:0] line;
        stall = (stall_fix >= 0) ? stall_fix : int'($urandom_range(0, stall_max));
        if (maddr_q.size() == 0 || mem_q.size() == 0) begin
            check("unexpected_mem_req", 0, 1);
            ea   = '0;
            line = '0;
        end else begin
            ea   = maddr_q.pop_front();
            line = mem_q.pop_front();
        end
        check("mem_req_addr", mem_req_addr_o, ea);
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            check("mem_req_stable", {mem_req_valid_o, mem_req_addr_o}, {1'b1, ea});
        end
        mem_req_ready_i = 1'b1;
        @(negedge clk);
        mem_req_ready_i = 1'b0;
        mem_txn++;
        @(negedge clk);
        for (int b = 0; b < BEATS; b++) begin
            if (abort_mode && b == 2) begin
                abort_cnt++;
                return;
            end
            repeat ($urandom_range(0, gap_max)) @(negedge clk);
            mem_rsp_valid_i = 1'b1;
            mem_rsp_data_i  = line[b*64 +: 64];
            mem_rsp_last_i  = (b == BEATS - 1) || (early_last && b == 1);
            @(negedge clk);
            mem_rsp_valid_i = 1'b0;
            mem_rsp_last_i  = 1'b0;
        end
    endtask

    initial begin : mem_model
        mem_req_ready_i = 1'b0;
        mem_rsp_valid_i = 1'b0;
        mem_rsp_data_i  = '0;
        mem_rsp_last_i  = 1'b0;
        forever begin
            @(negedge clk);
            if (stray_req != stray_done) begin
                mem_rsp_valid_i = 1'b1;
                mem_rsp_data_i  = {$urandom, $urandom};
                @(negedge clk);
                mem_rsp_valid_i = 1'b0;
                stray_done++;
            end else if (!reset && mem_req_valid_o) begin
                serve();
            end
        end
    end

    task automatic do_reset();
        reset        = 1'b1;
        l2_request_i = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_done", l2_done_o, 0);
        check("rst_data", l2_data_o, 0);
        check("rst_mem_valid", mem_req_valid_o, 0);
        check("rst_mem_addr", mem_req_addr_o, 0);
        check("rst_hits", hit_count_o, 0);
        check("rst_miss", miss_count_o, 0);
        check("rst_err", protocol_err_o, 0);
        reset = 1'b0;
        for (int i = 0; i < NL; i++) mv[i] = 1'b0;
        exp_hits = 0;
        exp_miss = 0;
        exp_q.delete();
        mem_q.delete();
        maddr_q.delete();
    endtask

    task automatic do_read(input logic [31:0] a, input bit hold, output int lat);
        int           idx;
        int           n;
        int unsigned  t0;
        logic [22:0]  tg;
        logic [255:0] line;
        idx = int'(a[8:5]);
        tg  = a[31:9];
        if (mv[idx] && mt[idx] == tg) begin
            exp_q.push_back(md[idx]);
            if (exp_hits < 16'hFFFF) exp_hits++;
        end else begin
            line = rand_line();
            mem_q.push_back(line);
            maddr_q.push_back({a[31:5], 5'b0});
            mv[idx] = 1'b1;
            mt[idx] = tg;
            md[idx] = line;
            exp_q.push_back(line);
            if (exp_miss < 16'hFFFF) exp_miss++;
        end
        issued++;
        @(negedge clk);
        l2_addr_i    = a;
        l2_request_i = 1'b1;
        t0           = cyc;
        n            = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!l2_done_o && n < 300);
        if (!l2_done_o) check("done_timeout", 0, 1);
        lat = int'(cyc - t0);
        if (!hold) l2_request_i = 1'b0;
        check("hit_count", hit_count_o, exp_hits);
        check("miss_count", miss_count_o, exp_miss);
    endtask

    initial begin : main
        int lat;
        int txn0;
        int n;
        logic [31:0] a;
        reset        = 1'b1;
        l2_request_i = 1'b0;
        l2_addr_i    = '0;
        repeat (2) @(negedge clk);
        do_reset();

        // Cold miss with a zero-stall memory, then a hit on another offset of the same line
        stall_fix = 0;
        gap_max   = 0;
        do_read(32'h0000_1040, 1'b0, lat);
        check("miss_latency", lat, 9);
        txn0 = mem_txn;
        do_read(32'h0000_105C, 1'b0, lat);
        check("hit_latency", lat, 3);
        check("hit_no_mem_req", mem_txn, txn0);

        // Conflict miss with a stalled memory, then the evicted line misses again
        stall_fix = 5;
        do_read(32'h0000_1240, 1'b0, lat);
        stall_fix = -1;
        gap_max   = 2;
        stall_max = 4;
        do_read(32'h0000_1040, 1'b0, lat);

        for (int i = 0; i < 60; i++) begin
            a = {23'($urandom_range(8, 10)), 4'($urandom), 5'($urandom)};
            do_read(a, (i != 59) && ($urandom_range(0, 1) == 1), lat);
        end
        check("err_clean_traffic", protocol_err_o, 0);

        // Early last: fill still runs to four beats, error is sticky
        early_last = 1'b1;
        do_read(32'h0004_0020, 1'b0, lat);
        early_last = 1'b0;
        check("err_early_last", protocol_err_o, 1);
        do_read(32'h0004_0020, 1'b0, lat);
        do_read(32'h0005_0060, 1'b0, lat);
        check("err_sticky", protocol_err_o, 1);

        // Reset during a fill after two beats
        abort_mode = 1'b1;
        stall_fix  = 0;
        gap_max    = 0;
        a = 32'h0000_3080;
        exp_q.push_back(rand_line());
        mem_q.push_back(exp_q[exp_q.size()-1]);
        maddr_q.push_back({a[31:5], 5'b0});
        txn0 = abort_cnt;
        @(negedge clk);
        l2_addr_i    = a;
        l2_request_i = 1'b1;
        n = 0;
        while (abort_cnt == txn0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("abort_reached", abort_cnt, txn0 + 1);
        abort_mode = 1'b0;
        check("abort_no_done", exp_q.size(), 1);
        do_reset();
        do_read(a, 1'b0, lat);
        check("abort_then_miss", miss_count_o, 1);

        // Stray beat while idle
        stray_req++;
        n = 0;
        while (stray_done != stray_req && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        check("err_stray", protocol_err_o, 1);

        // Hit counter saturation with back-to-back held requests
        do_reset();
        do_read(32'h0000_2000, 1'b0, lat);
        force dut.hit_cnt_q = 16'hFFFE;
        @(posedge clk);
        @(negedge clk);
        release dut.hit_cnt_q;
        @(negedge clk);
        check("hit_forced", hit_count_o, 16'hFFFE);
        exp_hits = 16'hFFFE;
        do_read(32'h0000_2000, 1'b1, lat);
        do_read(32'h0000_2004, 1'b1, lat);
        do_read(32'h0000_2008, 1'b0, lat);
        check("hit_saturated", hit_count_o, 16'hFFFF);

        repeat (5) @(negedge clk);
        check("done_count", dones, issued);
        check("sb_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
